// File: rtl/des_key_sched.sv
// DES key-schedule responder: loads a key, checks byte parity, applies PC-1 and
// precomputes the sixteen rotated C||D round values for indexed sub-key lookup.
module des_key_sched #(
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [63:0] key_in,
    input  logic        key_in_valid,
    input  logic        sub_key_req_valid_in,
    input  logic [3:0]  sub_key_req_idx_in,
    output logic [55:0] sub_key_out,
    output logic [3:0]  sub_key_idx_out,
    output logic        sub_key_out_valid,
    output logic        sub_key_req_err_out,
    output logic        check_done_out,
    output logic        check_error_out,
    output logic        key_ready_out
);
    localparam int unsigned KEY_W  = 64;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned HALF_W = 28;
    localparam int unsigned ROUNDS = 16;
    localparam int unsigned IDX_W  = 4;

    // Bit r set: round r rotates by one place, otherwise by two.
    localparam logic [ROUNDS-1:0] SHIFT_ONE = 16'b1000_0001_0000_0011;

    // PC-1 in FIPS bit numbering (bit 1 = key MSB); first 28 entries form C.
    localparam int unsigned PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_GEN, S_READY} state_t;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < CD_W; i++) begin
            r[CD_W-1-i] = k[KEY_W-PC1[i]];
        end
        return r;
    endfunction

    function automatic logic parity_bad(input logic [KEY_W-1:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < KEY_W / 8; b++) begin
            if (!(^k[8*b +: 8])) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input logic by_one);
        return by_one ? {v[HALF_W-2:0], v[HALF_W-1]} : {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
    endfunction

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [CD_W-1:0]   cd;
    logic [CD_W-1:0]   cd_next;
    logic              par_err;
    logic              tbl_valid;
    logic [CD_W-1:0]   round_tbl [ROUNDS];
    logic              by_one;

    always_comb begin
        by_one  = SHIFT_ONE[cnt];
        cd_next = {rotl(cd[CD_W-1:HALF_W], by_one), rotl(cd[HALF_W-1:0], by_one)};
    end

    // Table data is not reset; tbl_valid gates every read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            cd                  <= '0;
            par_err             <= 1'b0;
            tbl_valid           <= 1'b0;
            sub_key_out         <= '0;
            sub_key_idx_out     <= '0;
            sub_key_out_valid   <= 1'b0;
            sub_key_req_err_out <= 1'b0;
            check_done_out      <= 1'b0;
            check_error_out     <= 1'b0;
            key_ready_out       <= 1'b0;
        end else begin
            sub_key_out_valid   <= 1'b0;
            sub_key_req_err_out <= 1'b0;
            check_done_out      <= 1'b0;
            key_ready_out       <= (state == S_READY);

            // A request coinciding with a new load still reads the old table.
            if (sub_key_req_valid_in) begin
                if (state == S_READY && tbl_valid) begin
                    sub_key_out       <= round_tbl[sub_key_req_idx_in];
                    sub_key_idx_out   <= sub_key_req_idx_in;
                    sub_key_out_valid <= 1'b1;
                end else begin
                    sub_key_req_err_out <= 1'b1;
                end
            end

            case (state)
                S_IDLE, S_READY: begin
                    if (key_in_valid) begin
                        cd        <= pc1(key_in);
                        par_err   <= CHECK_PARITY & parity_bad(key_in);
                        tbl_valid <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    check_done_out  <= 1'b1;
                    check_error_out <= par_err;
                    if (par_err) begin
                        state <= S_IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= S_GEN;
                    end
                end
                S_GEN: begin
                    round_tbl[cnt] <= cd_next;
                    cd             <= cd_next;
                    cnt            <= cnt + IDX_W'(1);
                    if (cnt == IDX_W'(ROUNDS - 1)) begin
                        tbl_valid <= 1'b1;
                        state     <= S_READY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
